// File: rtl/uni_arbiter.sv
// Two-master to one-bridge request arbiter (instruction side m0, data side m1).
// Fixed priority m1 > m0 by default; define UNI_ARB_RR_EN for round-robin arbitration.
module uni_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_valid,
    input  logic              i_m0_reqtyp,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [1:0]        i_m0_size,
    input  logic              i_m0_cachable,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ready,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_valid,
    input  logic              i_m1_reqtyp,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [1:0]        i_m1_size,
    input  logic              i_m1_cachable,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ready,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_s_valid,
    output logic              o_s_reqtyp,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [1:0]        o_s_size,
    output logic              o_s_cachable,
    output logic [DATA_W-1:0] o_s_wdata,
    input  logic              i_s_ready,
    input  logic [DATA_W-1:0] i_s_rdata,
    output logic [1:0]        o_grant
);

    // state | meaning
    // IDLE  | no owner; arbitrate among valid requests
    // BUSY  | granted master drives the bridge until i_s_ready
    // GAP   | one-cycle bubble so bridge ready and requester valid both fall
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t     state_q;
    logic [1:0] grant_q;
    logic [1:0] win_d;
    logic       sel0, sel1;

`ifdef UNI_ARB_RR_EN
    logic last_q;  // 1 = m1 was granted last

    always_comb begin
        win_d = 2'b00;
        if (i_m1_valid && (!i_m0_valid || !last_q))
            win_d = 2'b10;
        else if (i_m0_valid)
            win_d = 2'b01;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_q <= 1'b0;
        else if (state_q == IDLE && win_d != 2'b00)
            last_q <= win_d[1];
    end
`else
    always_comb begin
        win_d = 2'b00;
        if (i_m1_valid)
            win_d = 2'b10;
        else if (i_m0_valid)
            win_d = 2'b01;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_d != 2'b00) begin
                        grant_q <= win_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_s_ready) begin
                        grant_q <= 2'b00;
                        state_q <= GAP;
                    end
                end
                GAP:     state_q <= IDLE;
                default: begin
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel0 = (state_q == BUSY) && grant_q[0];
    assign sel1 = (state_q == BUSY) && grant_q[1];

    // Request path is a pure mux so the bridge sees the owner's live inputs.
    always_comb begin
        o_s_valid    = 1'b0;
        o_s_reqtyp   = 1'b0;
        o_s_addr     = '0;
        o_s_size     = 2'b00;
        o_s_cachable = 1'b0;
        o_s_wdata    = '0;
        if (sel1) begin
            o_s_valid    = i_m1_valid;
            o_s_reqtyp   = i_m1_reqtyp;
            o_s_addr     = i_m1_addr;
            o_s_size     = i_m1_size;
            o_s_cachable = i_m1_cachable;
            o_s_wdata    = i_m1_wdata;
        end else if (sel0) begin
            o_s_valid    = i_m0_valid;
            o_s_reqtyp   = i_m0_reqtyp;
            o_s_addr     = i_m0_addr;
            o_s_size     = i_m0_size;
            o_s_cachable = i_m0_cachable;
            o_s_wdata    = i_m0_wdata;
        end
    end

    assign o_m0_ready = sel0 && i_s_ready;
    assign o_m1_ready = sel1 && i_s_ready;
    assign o_m0_rdata = i_s_rdata;
    assign o_m1_rdata = i_s_rdata;
    assign o_grant    = grant_q;

endmodule

// File: tb/tb_uni_arbiter.sv
// Scoreboard bench for uni_arbiter: stimulus queues expected completions,
// a negedge monitor checks each ready pulse against the queue head.
module tb_uni_arbiter;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_m0_valid, i_m0_reqtyp, i_m0_cachable;
    logic [31:0]  i_m0_addr;
    logic [1:0]   i_m0_size;
    logic [127:0] i_m0_wdata;
    logic         o_m0_ready;
    logic [127:0] o_m0_rdata;
    logic         i_m1_valid, i_m1_reqtyp, i_m1_cachable;
    logic [31:0]  i_m1_addr;
    logic [1:0]   i_m1_size;
    logic [127:0] i_m1_wdata;
    logic         o_m1_ready;
    logic [127:0] o_m1_rdata;
    logic         o_s_valid, o_s_reqtyp, o_s_cachable;
    logic [31:0]  o_s_addr;
    logic [1:0]   o_s_size;
    logic [127:0] o_s_wdata;
    logic         i_s_ready;
    logic [127:0] i_s_rdata;
    logic [1:0]   o_grant;

    always #5 i_clk = ~i_clk;

    uni_arbiter #(.ADDR_W(32), .DATA_W(128)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_valid(i_m0_valid), .i_m0_reqtyp(i_m0_reqtyp), .i_m0_addr(i_m0_addr),
        .i_m0_size(i_m0_size), .i_m0_cachable(i_m0_cachable), .i_m0_wdata(i_m0_wdata),
        .o_m0_ready(o_m0_ready), .o_m0_rdata(o_m0_rdata),
        .i_m1_valid(i_m1_valid), .i_m1_reqtyp(i_m1_reqtyp), .i_m1_addr(i_m1_addr),
        .i_m1_size(i_m1_size), .i_m1_cachable(i_m1_cachable), .i_m1_wdata(i_m1_wdata),
        .o_m1_ready(o_m1_ready), .o_m1_rdata(o_m1_rdata),
        .o_s_valid(o_s_valid), .o_s_reqtyp(o_s_reqtyp), .o_s_addr(o_s_addr),
        .o_s_size(o_s_size), .o_s_cachable(o_s_cachable), .o_s_wdata(o_s_wdata),
        .i_s_ready(i_s_ready), .i_s_rdata(i_s_rdata), .o_grant(o_grant)
    );

    typedef struct {
        int           m;
        logic [127:0] rdata;
        logic         typ;
        logic [31:0]  addr;
        logic [1:0]   size;
        logic [127:0] wdata;
        logic         valid;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [127:0] DEADBEEF = 128'h0123_4567_89ab_cdef_0000_0000_dead_beef;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && (o_m0_ready || o_m1_ready)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", {o_m1_ready, o_m0_ready}, 2'b00);
            end else begin
                exp_t e;
                logic [1:0] oh;
                e  = sb.pop_front();
                oh = (e.m == 1) ? 2'b10 : 2'b01;
                chk("ready_onehot", {o_m1_ready, o_m0_ready}, oh);
                chk("grant_at_ready", o_grant, oh);
                chk("s_valid", o_s_valid, e.valid);
                chk("s_reqtyp", o_s_reqtyp, e.typ);
                chk("s_addr", o_s_addr, e.addr);
                chk("s_size", o_s_size, e.size);
                chk("s_wdata", o_s_wdata, e.wdata);
                chk("m0_rdata", o_m0_rdata, e.rdata);
                chk("m1_rdata", o_m1_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input int m, input logic typ, input logic [31:0] a,
                       input logic [1:0] sz, input logic [127:0] wd);
        if (m == 1) begin
            i_m1_valid = 1'b1; i_m1_reqtyp = typ; i_m1_addr = a; i_m1_size = sz; i_m1_wdata = wd;
        end else begin
            i_m0_valid = 1'b1; i_m0_reqtyp = typ; i_m0_addr = a; i_m0_size = sz; i_m0_wdata = wd;
        end
    endtask

    task automatic complete(input int m, input logic [127:0] rd, input logic typ,
                            input logic [31:0] a, input logic [1:0] sz,
                            input logic [127:0] wd, input logic v);
        exp_t e;
        e.m = m; e.rdata = rd; e.typ = typ; e.addr = a; e.size = sz; e.wdata = wd; e.valid = v;
        sb.push_back(e);
        i_s_rdata = rd;
        i_s_ready = 1'b1;
    endtask

    task automatic idle_inputs();
        i_m0_valid = 0; i_m0_reqtyp = 0; i_m0_addr = 0; i_m0_size = 0; i_m0_cachable = 0; i_m0_wdata = 0;
        i_m1_valid = 0; i_m1_reqtyp = 0; i_m1_addr = 0; i_m1_size = 0; i_m1_cachable = 0; i_m1_wdata = 0;
        i_s_ready = 0; i_s_rdata = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_m;
        idle_inputs();
        i_rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_s_valid", o_s_valid, 1'b0);
        chk("rst_ready", {o_m1_ready, o_m0_ready}, 2'b00);
        i_rst_n = 1'b1;
        tick();

        // single m0 read
        req(0, 1'b0, 32'h0000_0100, 2'd2, 128'h0);
        chk("t1_pre_grant", o_grant, 2'b00);
        tick();
        chk("t1_grant", o_grant, 2'b01);
        chk("t1_s_valid", o_s_valid, 1'b1);
        chk("t1_s_addr", o_s_addr, 32'h0000_0100);
        tick(); tick();
        complete(0, DEADBEEF, 1'b0, 32'h0000_0100, 2'd2, 128'h0, 1'b1);
        tick();
        i_m0_valid = 1'b0;  // i_s_ready left high through GAP and IDLE: must be ignored
        chk("t1_gap_grant", o_grant, 2'b00);
        chk("t1_gap_s_valid", o_s_valid, 1'b0);
        chk("t1_gap_s_addr", o_s_addr, 32'h0);
        chk("t1_gap_ready", {o_m1_ready, o_m0_ready}, 2'b00);
        tick();
        chk("t1_idle_grant", o_grant, 2'b00);
        chk("t1_idle_ready", {o_m1_ready, o_m0_ready}, 2'b00);
        i_s_ready = 1'b0;
        tick();

        // simultaneous requests: m1 first, m0 after the bubble
        req(0, 1'b0, 32'h0000_0200, 2'd3, 128'h0);
        req(1, 1'b0, 32'h0000_0300, 2'd1, 128'h0);
        tick();
        chk("t2_grant_m1", o_grant, 2'b10);
        complete(1, 128'ha5a5, 1'b0, 32'h0000_0300, 2'd1, 128'h0, 1'b1);
        tick();
        i_s_ready = 1'b0; i_m1_valid = 1'b0;
        chk("t2_gap_grant", o_grant, 2'b00);
        tick();
        chk("t2_idle_grant", o_grant, 2'b00);
        tick();
        chk("t2_grant_m0", o_grant, 2'b01);
        complete(0, 128'h5a5a, 1'b0, 32'h0000_0200, 2'd3, 128'h0, 1'b1);
        tick();
        idle_inputs();
        tick();

        // m1 write; m0 arrives mid-transaction and must wait
        req(1, 1'b1, 32'h8000_0010, 2'd2, 128'h1122_3344);
        tick();
        chk("t3_grant", o_grant, 2'b10);
        chk("t3_s_reqtyp", o_s_reqtyp, 1'b1);
        chk("t3_s_addr", o_s_addr, 32'h8000_0010);
        chk("t3_s_wdata", o_s_wdata, 128'h1122_3344);
        req(0, 1'b0, 32'h0000_0040, 2'd0, 128'h0);
        tick();
        chk("t3_hold_grant", o_grant, 2'b10);
        chk("t3_m0_ready", o_m0_ready, 1'b0);
        complete(1, 128'h77, 1'b1, 32'h8000_0010, 2'd2, 128'h1122_3344, 1'b1);
        tick();
        i_s_ready = 1'b0; i_m1_valid = 1'b0;
        tick(); tick();
        chk("t3_grant_m0", o_grant, 2'b01);
        complete(0, 128'h88, 1'b0, 32'h0000_0040, 2'd0, 128'h0, 1'b1);
        tick();
        idle_inputs();
        tick();

        // granted master drops valid before completion: no abort
        req(0, 1'b0, 32'h0000_0600, 2'd2, 128'h0);
        tick();
        i_m0_valid = 1'b0;
        tick();
        chk("t4_hold_grant", o_grant, 2'b01);
        chk("t4_s_valid", o_s_valid, 1'b0);
        complete(0, 128'h99, 1'b0, 32'h0000_0600, 2'd2, 128'h0, 1'b0);
        tick();
        idle_inputs();
        tick();

        // both continuously valid for 4 transactions, from reset pointer
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        req(0, 1'b0, 32'h0000_0400, 2'd2, 128'h0);
        req(1, 1'b0, 32'h0000_0500, 2'd2, 128'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef UNI_ARB_RR_EN
            exp_m = (i % 2 == 0) ? 1 : 0;
`else
            exp_m = 1;
`endif
            tick();
            chk("t5_grant", o_grant, (exp_m == 1) ? 2'b10 : 2'b01);
            complete(exp_m, 128'h1000 + i, 1'b0, (exp_m == 1) ? 32'h0000_0500 : 32'h0000_0400,
                     2'd2, 128'h0, 1'b1);
            tick();
            i_s_ready = 1'b0;
            tick();
        end
        idle_inputs();
        tick();

        // reset mid-BUSY, then normal m0 request
        req(1, 1'b0, 32'h0000_0700, 2'd2, 128'h0);
        tick(); tick();
        chk("t6_busy_grant", o_grant, 2'b10);
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", o_grant, 2'b00);
        chk("t6_rst_s_valid", o_s_valid, 1'b0);
        i_m1_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
        req(0, 1'b0, 32'h0000_0800, 2'd1, 128'h0);
        tick();
        chk("t6_grant_m0", o_grant, 2'b01);
        complete(0, 128'hbeef, 1'b0, 32'h0000_0800, 2'd1, 128'h0, 1'b1);
        tick();
        idle_inputs();
        tick(); tick();

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
